// File: rtl/board_line_clearer.sv
// Compacts the board RAM after a piece locks: drops full rows, shifts the rows above down and zero-fills the top.
// One row access per cycle. A read and the evaluation of that row alternate, so the pass takes 2*HEIGHT + cleared cycles.
module board_line_clearer #(
   parameter int WIDTH  = 10,
   parameter int HEIGHT = 20,
   parameter int AW     = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    lines_cleared,
   output logic             rd_en,
   output logic [AW-1:0]    rd_addr,
   input  logic [WIDTH-1:0] rd_data,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [WIDTH-1:0] wr_data
);

   typedef enum logic [2:0] {IDLE, RD, EVAL, FILL, DONE} state_t;

   localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

   state_t          state, state_nxt;
   logic [AW-1:0]   src, src_nxt;
   logic [AW-1:0]   dst, dst_nxt;
   logic [AW-1:0]   cnt, cnt_nxt;
   logic            row_full;

   assign row_full      = &rd_data;
   assign lines_cleared = cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         src   <= '0;
         dst   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         src   <= src_nxt;
         dst   <= dst_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      src_nxt   = src;
      dst_nxt   = dst;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      done      = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;

      case (state)
         IDLE: begin
            if (start) begin
               src_nxt   = LAST_ROW;
               dst_nxt   = LAST_ROW;
               cnt_nxt   = '0;
               state_nxt = RD;
            end
         end

         RD: begin
            busy      = 1'b1;
            rd_en     = 1'b1;
            rd_addr   = src;
            state_nxt = EVAL;
         end

         EVAL: begin
            busy = 1'b1;
            if (row_full) begin
               cnt_nxt = cnt + AW'(1);
            end else begin
               // dst never passes src, so this row is already read or is the one in hand
               wr_en   = 1'b1;
               wr_addr = dst;
               wr_data = rd_data;
               dst_nxt = dst - AW'(1);
            end
            if (src == '0) begin
               state_nxt = (cnt_nxt != '0) ? FILL : DONE;
            end else begin
               src_nxt   = src - AW'(1);
               state_nxt = RD;
            end
         end

         FILL: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_addr = dst;
            if (dst == '0) begin
               state_nxt = DONE;
            end else begin
               dst_nxt = dst - AW'(1);
            end
         end

         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_board_line_clearer.sv
// Bench for board_line_clearer: a behavioural board RAM, a table of boards, and a write scoreboard per pass.
module tb_board_line_clearer;

   localparam int WIDTH  = 10;
   localparam int HEIGHT = 20;
   localparam int AW     = 5;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             busy, done, rd_en, wr_en;
   logic [AW-1:0]    lines_cleared, rd_addr, wr_addr;
   logic [WIDTH-1:0] rd_data, wr_data;

   board_line_clearer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous board RAM; load_req preloads the whole board in one cycle.
   logic [WIDTH-1:0]        mem [HEIGHT];
   logic                    load_req = 1'b0;
   logic [HEIGHT*WIDTH-1:0] load_board = '0;

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < HEIGHT; i++) mem[i] <= load_board[i*WIDTH +: WIDTH];
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) rd_data <= mem[rd_addr];
   end

   typedef struct {
      logic [HEIGHT*WIDTH-1:0] board;
      int                      exp_lines;
      bit                      repulse;
   } vec_t;

   vec_t vecs[6];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},    int'(busy),    0);
      check({tag, "_done"},    int'(done),    0);
      check({tag, "_rd_en"},   int'(rd_en),   0);
      check({tag, "_wr_en"},   int'(wr_en),   0);
      check({tag, "_rd_addr"}, int'(rd_addr), 0);
      check({tag, "_wr_addr"}, int'(wr_addr), 0);
      check({tag, "_wr_data"}, int'(wr_data), 0);
   endtask

   task automatic load(input logic [HEIGHT*WIDTH-1:0] b);
      @(negedge clk);
      load_board = b;
      load_req   = 1'b1;
      @(negedge clk);
      load_req   = 1'b0;
   endtask

   task automatic run_pass(input vec_t v);
      logic [AW+WIDTH-1:0] q[$];
      logic [AW+WIDTH-1:0] e;
      logic [WIDTH-1:0]    final_b [HEIGHT];
      logic [WIDTH-1:0]    row;
      int                  wp, k, n0, nreads, got, bad;

      // Expected writes: surviving rows bottom-up packed from row HEIGHT-1, then zeros above them.
      wp = HEIGHT - 1;
      for (int r = 0; r < HEIGHT; r++) final_b[r] = '0;
      for (int r = HEIGHT - 1; r >= 0; r--) begin
         row = v.board[r*WIDTH +: WIDTH];
         if (row != {WIDTH{1'b1}}) begin
            q.push_back({AW'(wp), row});
            final_b[wp] = row;
            wp--;
         end
      end
      for (int a = wp; a >= 0; a--) q.push_back({AW'(a), {WIDTH{1'b0}}});
      k = v.exp_lines;

      load(v.board);
      start  = 1'b1;
      n0     = cyc;
      nreads = 0;
      got    = 0;
      for (int t = 0; t < 120 && got == 0; t++) begin
         @(negedge clk);
         start = v.repulse && (cyc == n0 + 5 || cyc == n0 + 20);
         check("busy", int'(busy), int'(cyc <= n0 + 40 + k));
         check("rd_wr_overlap", int'(rd_en && wr_en), 0);
         if (rd_en) begin
            check("rd_addr", int'(rd_addr), HEIGHT - 1 - nreads);
            check("rd_cycle", cyc - n0, 1 + 2 * nreads);
            nreads++;
         end
         if (wr_en) begin
            if (q.size() == 0) begin
               check("extra_write", 1, 0);
            end else begin
               e = q.pop_front();
               check("wr_addr", int'(wr_addr), int'(e[AW+WIDTH-1:WIDTH]));
               check("wr_data", int'(wr_data), int'(e[WIDTH-1:0]));
            end
         end
         if (done) begin
            got = 1;
            check("done_latency", cyc - n0, 41 + k);
            check("lines_cleared", int'(lines_cleared), k);
         end
      end
      start = 1'b0;
      check("done_seen", got, 1);
      check("read_count", nreads, HEIGHT);
      check("writes_missing", q.size(), 0);

      bad = 0;
      for (int r = 0; r < HEIGHT; r++) if (mem[r] !== final_b[r]) bad++;
      check("board_rows_wrong", bad, 0);

      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         check("idle_done", int'(done), 0);
         check("idle_busy", int'(busy), 0);
         check("idle_rd_en", int'(rd_en), 0);
         check("held_lines", int'(lines_cleared), k);
      end
   endtask

   task automatic run_reset_midpass(input vec_t v);
      int n0;
      load(v.board);
      start = 1'b1;
      n0    = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < n0 + 10) @(negedge clk);
      check("pre_reset_busy", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      check("midreset_lines", int'(lines_cleared), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("post_reset");
   endtask

   initial begin
      for (int i = 0; i < 6; i++) begin
         vecs[i].board     = '0;
         vecs[i].exp_lines = 0;
         vecs[i].repulse   = 1'b0;
      end
      // 1: bottom row full
      vecs[1].board[19*WIDTH +: WIDTH] = 10'h3FF;
      vecs[1].board[18*WIDTH +: WIDTH] = 10'h001;
      vecs[1].exp_lines = 1;
      // 2: two full rows interleaved with partial rows
      vecs[2].board[19*WIDTH +: WIDTH] = 10'h3FF;
      vecs[2].board[18*WIDTH +: WIDTH] = 10'h155;
      vecs[2].board[17*WIDTH +: WIDTH] = 10'h3FF;
      vecs[2].board[16*WIDTH +: WIDTH] = 10'h2AA;
      vecs[2].exp_lines = 2;
      // 3: every row full
      vecs[3].board     = {HEIGHT*WIDTH{1'b1}};
      vecs[3].exp_lines = 20;
      // 4: same board as 2, with start re-pulsed mid-pass
      vecs[4]         = vecs[2];
      vecs[4].repulse = 1'b1;
      // 5: full rows at top, middle and row 10, other rows distinct partial data
      for (int r = 0; r < HEIGHT; r++)
         vecs[5].board[r*WIDTH +: WIDTH] = (r == 0 || r == 5 || r == 10) ? 10'h3FF : 10'(r * 37 + 1);
      vecs[5].exp_lines = 3;

      #2;
      check_idle_outputs("reset");
      check("reset_lines", int'(lines_cleared), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_pass(vecs[i]);

      run_reset_midpass(vecs[0]);
      run_pass(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/board_line_clearer.md
Name: board_line_clearer

Overview:
- Writer-side companion to the board scan/draw path: after a piece locks, it compacts the 10x20 board memory.
- Removes every completely filled row and shifts the rows above down, then zero-fills the vacated top rows.
- Talks to the board RAM through one read port and one write port, one full row per access.
- Reports how many lines it cleared to the scoring/game FSM.

Parameters:
- WIDTH, 10, cells per row (row word width).
- HEIGHT, 20, number of rows; row 0 is the top, row HEIGHT-1 is the bottom.
- AW, 5, row address width; must satisfy 2^AW >= HEIGHT.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a clear pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle pulse when the pass is complete.
- lines_cleared  out  AW  number of full rows removed in the last pass.
- rd_en  out  1  row read strobe.
- rd_addr  out  AW  row being read.
- rd_data  in  WIDTH  row contents; valid exactly one cycle after rd_en (synchronous RAM).
- wr_en  out  1  row write strobe.
- wr_addr  out  AW  row being written.
- wr_data  out  WIDTH  row contents to write.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; busy, done, rd_en and wr_en are 0.
  - lines_cleared, rd_addr, wr_addr and wr_data are 0.
- Internal registers:
  - src: read pointer.
  - dst: write pointer.
  - cnt: cleared-line count; drives lines_cleared directly.
- States: IDLE, RD, EVAL, FILL, DONE.
- IDLE, start=1: src=HEIGHT-1, dst=HEIGHT-1, cnt=0; go to RD.
- IDLE, start=0: remain in IDLE; lines_cleared holds the previous result.
- RD: rd_en=1, rd_addr=src; go to EVAL.
- EVAL: rd_data holds row src.
  - Row full (rd_data all ones): no write; cnt<=cnt+1.
  - Row not full: wr_en=1, wr_addr=dst, wr_data=rd_data; dst<=dst-1.
  - Writes occur even when src==dst; the rewritten data is identical.
  - If src==0: go to FILL when cnt (including this row) > 0, else go to DONE.
  - If src!=0: src<=src-1; go to RD.
- FILL: wr_en=1, wr_addr=dst, wr_data=0.
  - If dst==0: go to DONE. Otherwise dst<=dst-1 and stay in FILL.
  - FILL writes exactly cnt rows, at addresses cnt-1 down to 0.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- Hazard-free by construction:
  - dst>=src always holds.
  - Every write targets a row already read or the row currently being evaluated.
- Latency, with start high in cycle N and k lines cleared:
  - First rd_en in cycle N+1.
  - Last EVAL in cycle N+40.
  - done in cycle N+41+k.
- busy is high in cycles N+1 through N+40+k.
- start while busy, or in the DONE cycle: ignored.
- rd_en and wr_en are never high in the same cycle: rd_en only in RD, wr_en only in EVAL/FILL.
- Counter widths:
  - dst may decrement below 0 only on the final EVAL into DONE; the wrapped value is don't-care.
  - cnt max is HEIGHT (20), which fits in AW bits.
- Reset mid-pass: return to IDLE immediately with all outputs zero. Board contents are then undefined; the game FSM must reinitialise the board.

Test Plan:
- Empty board, start pulse -> 20 reads and 20 identical writes (rows 19..0), no FILL, done at N+41, lines_cleared=0.
- Only row 19 full, row 18=10'h001, rows 0..17 empty -> row 19 written 10'h001, rows 18..0 written 0, lines_cleared=1, done at N+42.
- Rows 19 and 17 full, row 18=10'h155, row 16=10'h2AA -> row 19=10'h155, row 18=10'h2AA, rows 1,0 filled 0, lines_cleared=2, done at N+43.
- All 20 rows full (10'h3FF) -> no EVAL writes, FILL writes 0 to rows 19..0, lines_cleared=20, done at N+61.
- start re-pulsed at N+5 and N+20 during a pass -> no restart; only one done; result identical to the single-start run.
- reset_n low at N+10 -> busy/done/rd_en/wr_en go to 0 asynchronously; after release, a fresh start completes a normal pass.
